// File: rtl/rotate_pkg.sv
// Shared types for the rotate controller: debounce FSM states and speed indices.
package rotate_pkg;

  typedef enum logic [1:0] {
    DB_LOW       = 2'd0,
    DB_WAIT_HIGH = 2'd1,
    DB_HIGH      = 2'd2,
    DB_WAIT_LOW  = 2'd3
  } db_state_e;

  typedef enum logic [1:0] {
    SPD_1X = 2'd0,
    SPD_2X = 2'd1,
    SPD_4X = 2'd2,
    SPD_8X = 2'd3
  } speed_e;

  function automatic speed_e next_speed(input speed_e s);
    return speed_e'(s + 2'd1);
  endfunction

  // Step period in clock cycles: each speed index doubles the step rate.
  function automatic int unsigned step_period(input int unsigned base, input speed_e s);
    return base >> s;
  endfunction

endpackage

// File: rtl/rotate_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, 4-state debounce, one-cycle press pulse.
module btn_debounce
  import rotate_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned   CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          btn_s;
  db_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

  assign btn_s   = sync_q[1];
  assign press_o = press_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[0], btn_i};
  end

  // The sample that leaves a stable state counts as the first of the DB_CYCLES run.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DB_LOW;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      unique case (state_q)
        DB_LOW: begin
          if (btn_s) begin
            state_q <= DB_WAIT_HIGH;
            cnt_q   <= CW'(1);
          end
        end
        DB_WAIT_HIGH: begin
          if (!btn_s) begin
            state_q <= DB_LOW;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= DB_HIGH;
            cnt_q   <= '0;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DB_HIGH: begin
          if (!btn_s) begin
            state_q <= DB_WAIT_LOW;
            cnt_q   <= CW'(1);
          end
        end
        DB_WAIT_LOW: begin
          if (btn_s) begin
            state_q <= DB_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= DB_LOW;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/rotate_ctrl.sv
// LED rotator control: debounced buttons drive direction/speed/run, plus the step strobe timer.
module rotate_ctrl
  import rotate_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned BASE_DIV  = 3_125_000
) (
  input  logic       clk_out2,
  input  logic       rst,
  input  logic       btn_dir,
  input  logic       btn_speed,
  input  logic       btn_pause,
  output logic       direction,
  output logic       step_en,
  output logic [1:0] speed,
  output logic       running
);

  localparam int unsigned CW = $clog2(BASE_DIV);

  logic          press_dir, press_speed, press_pause;
  logic          dir_q, dir_d;
  logic          run_q, run_d;
  logic          step_q, step_d;
  speed_e        speed_q, speed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_last;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
    .clk_i   (clk_out2),
    .rst_i   (rst),
    .btn_i   (btn_dir),
    .press_o (press_dir)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_speed (
    .clk_i   (clk_out2),
    .rst_i   (rst),
    .btn_i   (btn_speed),
    .press_o (press_speed)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk_i   (clk_out2),
    .rst_i   (rst),
    .btn_i   (btn_pause),
    .press_o (press_pause)
  );

  always_comb begin
    cnt_last = CW'(step_period(BASE_DIV, speed_q) - 32'd1);
  end

  // A speed change restarts the period; otherwise the strobe uses the pre-press run state.
  always_comb begin
    dir_d   = dir_q ^ press_dir;
    run_d   = run_q ^ press_pause;
    speed_d = press_speed ? next_speed(speed_q) : speed_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    if (press_speed) begin
      cnt_d = '0;
    end else if (run_q) begin
      if (cnt_q == cnt_last) begin
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_out2 or posedge rst) begin
    if (rst) begin
      dir_q   <= 1'b0;
      run_q   <= 1'b1;
      speed_q <= SPD_1X;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      run_q   <= run_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  assign direction = dir_q;
  assign step_en   = step_q;
  assign speed     = speed_q;
  assign running   = run_q;

endmodule

// File: tb/tb_rotate_ctrl.sv
// Bench for rotate_ctrl: run-length debounce model plus elapsed-cycle step model, checked every cycle.
`timescale 1ns/1ps
module tb_rotate_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned BD = 16;

  logic       clk_out2 = 1'b0;
  logic       rst;
  logic       btn_dir, btn_speed, btn_pause;
  logic       direction, step_en, running;
  logic [1:0] speed;

  always #5 clk_out2 = ~clk_out2;

  rotate_ctrl #(.DB_CYCLES(DB), .BASE_DIV(BD)) dut (
    .clk_out2  (clk_out2),
    .rst       (rst),
    .btn_dir   (btn_dir),
    .btn_speed (btn_speed),
    .btn_pause (btn_pause),
    .direction (direction),
    .step_en   (step_en),
    .speed     (speed),
    .running   (running)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: buttons seen two edges late; a level is accepted after DB
  // consecutive differing samples; presses act one edge later; a strobe fires when
  // the cycles elapsed while running reach BASE_DIV >> speed.
  int m_dir = 0, m_spd = 0, m_run = 1, m_step = 0, m_elapsed = 0;
  int sy1[3], sy2[3], lvl[3], runlen[3], pr[3];

  always @(posedge clk_out2) begin
    int raw [3];
    int in_b;
    int n;
    raw[0] = int'(btn_dir);
    raw[1] = int'(btn_speed);
    raw[2] = int'(btn_pause);
    if (rst) begin
      m_dir = 0; m_spd = 0; m_run = 1; m_step = 0; m_elapsed = 0;
      for (int i = 0; i < 3; i++) begin
        sy1[i] = 0; sy2[i] = 0; lvl[i] = 0; runlen[i] = 0; pr[i] = 0;
      end
    end else begin
      n = int'(BD) >> m_spd;
      if (pr[1] != 0) begin
        m_elapsed = 0;
        m_step    = 0;
      end else if (m_run != 0) begin
        m_elapsed++;
        m_step = (m_elapsed == n) ? 1 : 0;
        if (m_step != 0) m_elapsed = 0;
      end else begin
        m_step = 0;
      end
      if (pr[0] != 0) m_dir = 1 - m_dir;
      if (pr[1] != 0) m_spd = (m_spd + 1) % 4;
      if (pr[2] != 0) m_run = 1 - m_run;
      for (int i = 0; i < 3; i++) begin
        in_b   = sy2[i];
        sy2[i] = sy1[i];
        sy1[i] = raw[i];
        pr[i]  = 0;
        if (in_b != lvl[i]) begin
          runlen[i]++;
          if (runlen[i] == int'(DB)) begin
            lvl[i]    = in_b;
            runlen[i] = 0;
            pr[i]     = in_b;
          end
        end else begin
          runlen[i] = 0;
        end
      end
    end
  end

  always @(negedge clk_out2) begin
    if (rst) begin
      chk("rst_direction", int'(direction), 0);
      chk("rst_speed",     int'(speed),     0);
      chk("rst_running",   int'(running),   1);
      chk("rst_step_en",   int'(step_en),   0);
    end else begin
      chk("direction", int'(direction), m_dir);
      chk("speed",     int'(speed),     m_spd);
      chk("running",   int'(running),   m_run);
      chk("step_en",   int'(step_en),   m_step);
    end
  end

  task automatic tick();
    @(posedge clk_out2);
    #1;
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0:       btn_dir   = v;
      1:       btn_speed = v;
      default: btn_pause = v;
    endcase
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  initial begin
    int k, d, s, t, strobes, changes, at;
    logic [1:0] old;
    logic prev;
    int nexp [4];
    int hold [3];
    nexp = '{8, 4, 2, 16};
    hold = '{0, 0, 0};

    rst = 1'b1; btn_dir = 1'b0; btn_speed = 1'b0; btn_pause = 1'b0;
    repeat (3) tick();
    chk("reset_direction", int'(direction), 0);
    chk("reset_speed",     int'(speed),     0);
    chk("reset_running",   int'(running),   1);
    chk("reset_step_en",   int'(step_en),   0);
    @(negedge clk_out2);
    rst = 1'b0;

    // Idle after reset: strobes at edges 16, 32, 48, 64.
    strobes = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (step_en) begin
        chk("idle_strobe_edge", i, 16 * (strobes + 1));
        strobes++;
      end
    end
    chk("idle_strobe_count", strobes, 4);

    // Held direction button: one toggle, 7 edges after the raw rise.
    btn_dir = 1'b1; prev = direction; changes = 0; at = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (direction != prev) begin
        changes++; at = i; prev = direction;
      end
      if (i == 10) btn_dir = 1'b0;
    end
    chk("dir_toggle_count", changes, 1);
    chk("dir_toggle_edge",  at,      7);
    chk("dir_after_press",  int'(direction), 1);

    // Short glitches never produce a press.
    for (int r = 0; r < 5; r++) begin
      btn_dir = 1'b1; repeat (3) tick();
      btn_dir = 1'b0; repeat (5) tick();
    end
    chk("dir_after_glitches", int'(direction), 1);

    // Speed presses: first strobe and period both equal BASE_DIV >> speed.
    for (int p = 0; p < 4; p++) begin
      old = speed; btn_speed = 1'b1; t = 0;
      while (speed == old && t < 20) begin tick(); t++; end
      chk("speed_value", int'(speed), (p + 1) % 4);
      d = 0;
      do begin tick(); d++; end while (!step_en && d < 40);
      chk("speed_first_strobe", d, nexp[p]);
      d = 0;
      do begin tick(); d++; end while (!step_en && d < 40);
      chk("speed_period", d, nexp[p]);
      btn_speed = 1'b0; repeat (10) tick();
    end

    // Pause pulse lands while the step count is 5; resume strobe after 10 edges.
    d = 0;
    do begin tick(); d++; end while (!step_en && d < 40);
    chk("pause_sync_strobe", int'(step_en), 1);
    repeat (15) tick();
    btn_pause = 1'b1; k = 0;
    while (running && k < 20) begin tick(); k++; end
    chk("pause_edge", k, 7);
    btn_pause = 1'b0;
    s = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (step_en) s++;
    end
    chk("paused_strobes", s, 0);
    chk("paused_running", int'(running), 0);
    btn_pause = 1'b1; k = 0;
    while (!running && k < 20) begin tick(); k++; end
    chk("resume_edge", k, 7);
    d = 0;
    do begin tick(); d++; end while (!step_en && d < 40);
    chk("resume_first_strobe", d, 10);
    btn_pause = 1'b0; repeat (10) tick();

    // Reset in the middle of a direction debounce at speed 2.
    for (int r = 0; r < 2; r++) begin
      btn_speed = 1'b1; repeat (8) tick();
      btn_speed = 1'b0; repeat (8) tick();
    end
    chk("pre_rst_speed",     int'(speed),     2);
    chk("pre_rst_direction", int'(direction), 1);
    btn_dir = 1'b1; repeat (4) tick();
    @(negedge clk_out2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_direction", int'(direction), 0);
    chk("async_rst_speed",     int'(speed),     0);
    chk("async_rst_running",   int'(running),   1);
    chk("async_rst_step_en",   int'(step_en),   0);
    repeat (3) tick();
    @(negedge clk_out2);
    rst = 1'b0; k = 0;
    while (!direction && k < 20) begin tick(); k++; end
    chk("post_rst_dir_edge", k, 7);
    btn_dir = 1'b0; repeat (10) tick();

    // Random button activity with one mid-run reset, checked cycle by cycle.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          set_btn(i, logic'($urandom_range(0, 1)));
          hold[i] = int'($urandom_range(1, 9));
        end else begin
          hold[i]--;
        end
      end
      if (c == 200) rst = 1'b1;
      if (c == 202) rst = 1'b0;
      tick();
    end

    btn_dir = 1'b0; btn_speed = 1'b0; btn_pause = 1'b0;
    repeat (20) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
